// File: rtl/sonic_rx_ctl_66_pkg.sv
// Shared types and defaults for the RX ring-buffer controller.
//   rx_ctl_state_e     : controller state encoding
//   *_DEF localparams  : default ring geometry, chunk size and flush timeout
package sonic_rx_ctl_66_pkg;

    localparam int unsigned BLOCK_WIDTH       = 66;
    localparam int unsigned PTR_WIDTH_DEF     = 14;
    localparam int unsigned CHUNK_QWORDS_DEF  = 32'h200;
    localparam int unsigned FLUSH_TIMEOUT_DEF = 4096;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SYNC  = 2'd1,
        RX_RUN   = 2'd2,
        RX_FLUSH = 2'd3
    } rx_ctl_state_e;

endpackage

// File: rtl/sonic_rx_chunk_tracker.sv
// Chunk bookkeeping for the RX ring: counts qwords written since the last
// notification, issues a full chunk when CHUNK_QWORDS accumulate, and a
// partial chunk on flush request or after FLUSH_TIMEOUT cycles of waiting.
//   clock, reset_n : clock / async active-low reset
//   clear          : return to empty ring at address 0
//   wr             : one qword written this cycle
//   flush          : emit whatever is pending
//   chunk_ready    : one-cycle notification; chunk_base/chunk_len valid with it
module sonic_rx_chunk_tracker
    import sonic_rx_ctl_66_pkg::*;
#(
    parameter int unsigned PTR_WIDTH     = PTR_WIDTH_DEF,
    parameter int unsigned CHUNK_QWORDS  = CHUNK_QWORDS_DEF,
    parameter int unsigned FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 wr,
    input  logic                 flush,
    output logic                 chunk_ready,
    output logic [PTR_WIDTH-1:0] chunk_base,
    output logic [PTR_WIDTH-1:0] chunk_len
);

    localparam int unsigned TMR_W = $clog2(FLUSH_TIMEOUT) + 1;

    logic [PTR_WIDTH-1:0] pending;
    logic [PTR_WIDTH-1:0] start;
    logic [TMR_W-1:0]     timer;
    logic                 emit_full_c;
    logic                 emit_part_c;

    // Full chunk wins over a coincident timeout or flush.
    always_comb begin
        emit_full_c = wr && (pending == PTR_WIDTH'(CHUNK_QWORDS - 1));
        emit_part_c = !emit_full_c && (pending != '0) &&
                      (flush || (timer == TMR_W'(FLUSH_TIMEOUT - 1)));
    end

    // A write coinciding with a partial emission opens the next chunk.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending     <= '0;
            start       <= '0;
            timer       <= '0;
            chunk_ready <= 1'b0;
            chunk_base  <= '0;
            chunk_len   <= '0;
        end else begin
            chunk_ready <= emit_full_c || emit_part_c;
            if (emit_full_c) begin
                chunk_base <= start;
                chunk_len  <= PTR_WIDTH'(CHUNK_QWORDS);
                start      <= start + PTR_WIDTH'(CHUNK_QWORDS);
                pending    <= '0;
                timer      <= '0;
            end else if (emit_part_c) begin
                chunk_base <= start;
                chunk_len  <= pending;
                start      <= start + pending;
                pending    <= PTR_WIDTH'(wr);
                timer      <= '0;
            end else begin
                pending <= pending + PTR_WIDTH'(wr);
                timer   <= (pending != '0) ? timer + TMR_W'(1) : '0;
            end
            if (clear) begin
                pending <= '0;
                start   <= '0;
                timer   <= '0;
            end
        end
    end

endmodule

// File: rtl/sonic_rx_ctl_66.sv
// RX ring-buffer controller: writes gearbox blocks into the circular buffer,
// guards against overrunning the host read pointer, counts drops and hands
// chunk notifications to the DMA write engine.
//   clock, reset_n               : RX clock / async active-low reset
//   enable, block_lock           : software enable, block sync status
//   data_in, data_valid          : incoming 66-bit blocks
//   host_rptr, host_rptr_valid   : host read pointer update
//   mem_wr_en/addr/data          : buffer write port
//   rx_ring_wptr                 : next write pointer
//   chunk_ready/base/len         : chunk notification
//   overflow, drop_count         : drop accounting
module sonic_rx_ctl_66
    import sonic_rx_ctl_66_pkg::*;
#(
    parameter int unsigned PTR_WIDTH     = PTR_WIDTH_DEF,
    parameter int unsigned CHUNK_QWORDS  = CHUNK_QWORDS_DEF,
    parameter int unsigned FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEF
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   block_lock,
    input  logic [BLOCK_WIDTH-1:0] data_in,
    input  logic                   data_valid,
    input  logic [PTR_WIDTH-1:0]   host_rptr,
    input  logic                   host_rptr_valid,
    output logic                   mem_wr_en,
    output logic [PTR_WIDTH-1:0]   mem_wr_addr,
    output logic [BLOCK_WIDTH-1:0] mem_wr_data,
    output logic [PTR_WIDTH-1:0]   rx_ring_wptr,
    output logic                   chunk_ready,
    output logic [PTR_WIDTH-1:0]   chunk_base,
    output logic [PTR_WIDTH-1:0]   chunk_len,
    output logic                   overflow,
    output logic [31:0]            drop_count
);

    rx_ctl_state_e        state;
    rx_ctl_state_e        state_next;
    logic [PTR_WIDTH-1:0] wptr;
    logic [PTR_WIDTH-1:0] rptr;
    logic [PTR_WIDTH-1:0] used_c;
    logic                 full_c;
    logic                 wr_c;
    logic                 drop_c;
    logic                 flush_c;
    logic                 clear_c;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= RX_IDLE;
        else          state <= state_next;
    end

    // Next-state logic; leaving RUN always passes through FLUSH.
    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:  if (enable) state_next = RX_SYNC;
            RX_SYNC:  if (!enable) state_next = RX_IDLE;
                      else if (block_lock) state_next = RX_RUN;
            RX_RUN:   if (!enable || !block_lock) state_next = RX_FLUSH;
            RX_FLUSH: state_next = enable ? RX_SYNC : RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    // One slot stays empty so wptr == rptr always means empty.
    always_comb begin
        used_c  = wptr - rptr;
        full_c  = (used_c == '1);
        wr_c    = (state == RX_RUN) && data_valid && !full_c;
        drop_c  = (state == RX_RUN) && data_valid && full_c;
        flush_c = (state == RX_FLUSH);
        clear_c = (state_next == RX_IDLE);
    end

    // Pointers, write port and drop accounting; entering IDLE empties the ring.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr        <= '0;
            rptr        <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            mem_wr_en <= wr_c;
            if (wr_c) begin
                mem_wr_addr <= wptr;
                mem_wr_data <= data_in;
                wptr        <= wptr + PTR_WIDTH'(1);
            end
            if (drop_c) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + 32'd1;
            end
            if ((state != RX_IDLE) && host_rptr_valid) rptr <= host_rptr;
            if (clear_c) begin
                wptr       <= '0;
                rptr       <= '0;
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end
    end

    assign rx_ring_wptr = wptr;

    sonic_rx_chunk_tracker #(
        .PTR_WIDTH     (PTR_WIDTH),
        .CHUNK_QWORDS  (CHUNK_QWORDS),
        .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
    ) u_chunk_tracker (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear       (clear_c),
        .wr          (wr_c),
        .flush       (flush_c),
        .chunk_ready (chunk_ready),
        .chunk_base  (chunk_base),
        .chunk_len   (chunk_len)
    );

endmodule
